codalu_chk: RTL

Sequence checker for the codalu digit stream; it sits at the receiving end of the 4-bit symbol sequencer.
- Consumes one 4-bit symbol per valid cycle.
- Aligns to the selected code sequence and reports lock, frame completions and mismatches.
- Used on-board to verify a sequencer output, or a recovered copy of it, in real time.

---
 rtl/codalu_chk.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/codalu_chk.sv
// Receive-side checker for the codalu symbol sequencer: aligns to the long or
// short code, tracks frame position, and reports lock, frame completions and errors.
module codalu_chk #(
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       din,
  input  logic             din_vld,
  input  logic             mode,
  output logic             lock,
  output logic             err,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       pos
);

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_pos;
  logic [3:0]       w_pos_next;
  logic [3:0]       r_good;
  logic [3:0]       w_good_next;
  logic             r_lock;
  logic             w_lock_next;
  logic             r_err;
  logic             w_err_next;
  logic             r_fd;
  logic             w_fd_next;
  logic             r_mode_q;
  logic             w_mode_chg;
  logic             w_fc_inc;
  logic             w_ec_inc;
  logic [3:0]       w_exp;
  logic [3:0]       w_first;
  logic [3:0]       w_last;
  logic [CNT_W-1:0] r_fc;
  logic [CNT_W-1:0] r_ec;

  // Symbol k (1-based) of the selected code; 0 outside the frame.
  function automatic logic [3:0] sym_at(input logic m, input logic [3:0] k);
    logic [3:0] s;
    s = 4'd0;
    if (m) begin
      case (k)
        4'd1:    s = 4'd1;
        4'd2:    s = 4'd5;
        4'd3:    s = 4'd3;
        4'd4:    s = 4'd1;
        4'd5:    s = 4'd1;
        default: s = 4'd0;
      endcase
    end else begin
      case (k)
        4'd1:    s = 4'd2;
        4'd2:    s = 4'd1;
        4'd3:    s = 4'd5;
        4'd4:    s = 4'd4;
        4'd5:    s = 4'd3;
        4'd6:    s = 4'd1;
        4'd7:    s = 4'd1;
        4'd8:    s = 4'd6;
        4'd9:    s = 4'd4;
        default: s = 4'd0;
      endcase
    end
    return s;
  endfunction

  assign w_mode_chg = (mode != r_mode_q);
  assign w_exp      = sym_at(r_mode_q, r_pos);
  assign w_first    = sym_at(r_mode_q, 4'd1);
  assign w_last     = r_mode_q ? 4'd5 : 4'd9;

  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    w_good_next  = r_good;
    w_lock_next  = r_lock;
    w_err_next   = 1'b0;
    w_fd_next    = 1'b0;
    w_fc_inc     = 1'b0;
    w_ec_inc     = 1'b0;
    if (w_mode_chg) begin
      // The code changed under us: drop alignment, never flag it as an error.
      if (r_state == TRACK) begin
        w_state_next = HUNT;
        w_pos_next   = 4'd0;
        w_lock_next  = 1'b0;
        w_good_next  = 4'd0;
      end
    end else if (din_vld) begin
      case (r_state)
        HUNT: begin
          if (din == w_first) begin
            w_state_next = TRACK;
            w_pos_next   = 4'd2;
          end
        end
        TRACK: begin
          if (din == w_exp) begin
            if (r_pos == w_last) begin
              // Frames are back-to-back: next expected symbol is symbol 1.
              w_fd_next  = 1'b1;
              w_fc_inc   = 1'b1;
              w_pos_next = 4'd1;
              if (r_good < LOCK_N) begin
                w_good_next = r_good + 4'd1;
              end
              if (r_good >= LOCK_N - 4'd1) begin
                w_lock_next = 1'b1;
              end
            end else begin
              w_pos_next = r_pos + 4'd1;
            end
          end else begin
            if (r_lock) begin
              w_err_next = 1'b1;
              w_ec_inc   = 1'b1;
            end
            w_lock_next = 1'b0;
            w_good_next = 4'd0;
            // Re-examine the offending symbol as a possible frame start.
            if (din == w_first) begin
              w_pos_next = 4'd2;
            end else begin
              w_state_next = HUNT;
              w_pos_next   = 4'd0;
            end
          end
        end
        default: begin
          w_state_next = HUNT;
          w_pos_next   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= HUNT;
      r_pos    <= 4'd0;
      r_good   <= 4'd0;
      r_lock   <= 1'b0;
      r_err    <= 1'b0;
      r_fd     <= 1'b0;
      r_mode_q <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pos    <= w_pos_next;
      r_good   <= w_good_next;
      r_lock   <= w_lock_next;
      r_err    <= w_err_next;
      r_fd     <= w_fd_next;
      r_mode_q <= mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fc <= '0;
      r_ec <= '0;
    end else begin
      if (w_fc_inc && (r_fc != CNT_MAX)) begin
        r_fc <= r_fc + CNT_W'(1);
      end
      if (w_ec_inc && (r_ec != CNT_MAX)) begin
        r_ec <= r_ec + CNT_W'(1);
      end
    end
  end

  assign lock       = r_lock;
  assign err        = r_err;
  assign frame_done = r_fd;
  assign frame_cnt  = r_fc;
  assign err_cnt    = r_ec;
  assign pos        = r_pos;

endmodule
